// File: rtl/q_learn_pkg.sv
// Shared types and constants for the Q-learning maze scheduler.
package q_learn_pkg;

  localparam int STATE_W     = 6;
  localparam int NUM_STATES  = 37;
  localparam int NUM_ACTIONS = 4;
  // Wait cycles allowed for a datapath unit before the watchdog trips
  localparam int WD_LIMIT    = 255;

  typedef logic [STATE_W-1:0] maze_state_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    MAXQ      = 3'd2,
    UPDATE    = 3'd3,
    TRIAL     = 3'd4,
    CHECK     = 3'd5,
    DONE      = 3'd6
  } sched_state_t;

endpackage

// File: rtl/q_sched_watchdog.sv
// Wait-cycle counter for the scheduler handshakes. expire is raised on the
// WD_LIMIT-th enabled cycle after the last clear, unless clear is active.
module q_sched_watchdog
  import q_learn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] cnt_reg;

  // Count enabled cycles since the last clear, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= 8'd0;
    end else if (enable && (cnt_reg != 8'hFF)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign expire = enable && !clear && (cnt_reg == 8'(WD_LIMIT - 1));

endmodule

// File: rtl/q_episode_sched.sv
// Episode/step sequencer for the Q-learning maze engine. Drives the max-Q,
// Q-update and trial-move units through one-cycle go pulses and tracks the
// episode and step counters.
// Optional feature: define Q_SCHED_WATCHDOG_EN to bound every unit wait and
// report a sticky err on timeout; otherwise waits are unbounded and err is 0.
module q_episode_sched
  import q_learn_pkg::*;
#(
  parameter int N_EPISODES = 11,
  parameter int MAX_STEPS  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               init_done,
  input  logic [STATE_W-1:0] start_state,
  input  logic [STATE_W-1:0] target_state,
  output logic               maxq_go,
  output logic               update_go,
  output logic               trial_go,
  input  logic               maxq_done,
  input  logic               update_done,
  input  logic               trial_done,
  input  logic [STATE_W-1:0] trial_next,
  output logic [STATE_W-1:0] cur_state,
  output logic [7:0]         episode,
  output logic [7:0]         step,
  output logic               busy,
  output logic               learn_done,
  output logic               err
);

  if (N_EPISODES < 1 || N_EPISODES > 255 || MAX_STEPS < 1 || MAX_STEPS > 255) begin : g_bad_params
    $error("q_episode_sched: N_EPISODES and MAX_STEPS must be in 1..255");
  end

  localparam logic [8:0] N_EP_LIM  = 9'(N_EPISODES);
  localparam logic [8:0] STEP_LIM  = 9'(MAX_STEPS);

  sched_state_t state_reg;
  maze_state_t  cur_state_reg;
  maze_state_t  next_reg;
  logic [7:0]   episode_reg;
  logic [7:0]   step_reg;
  logic         maxq_go_reg;
  logic         update_go_reg;
  logic         trial_go_reg;
  logic         busy_reg;
  logic         learn_done_reg;

  logic         target_hit;
  logic         step_cap;
  logic         last_episode;
  logic [7:0]   episode_inc;
  logic [7:0]   step_inc;

  assign target_hit   = (next_reg == target_state);
  assign step_cap     = (({1'b0, step_reg} + 9'd1) == STEP_LIM);
  assign last_episode = (({1'b0, episode_reg} + 9'd1) == N_EP_LIM);
  assign episode_inc  = (episode_reg == 8'hFF) ? episode_reg : episode_reg + 8'd1;
  assign step_inc     = (step_reg == 8'hFF) ? step_reg : step_reg + 8'd1;

`ifdef Q_SCHED_WATCHDOG_EN
  logic wd_expire;
  logic in_wait;
  logic err_reg;

  assign in_wait = (state_reg == MAXQ) || (state_reg == UPDATE) || (state_reg == TRIAL);

  // Restart the count on every go pulse so each unit gets its own budget
  q_sched_watchdog u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait || maxq_go_reg || update_go_reg || trial_go_reg),
    .enable (in_wait),
    .expire (wd_expire)
  );

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // Main scheduler FSM; go pulses are asserted for the entry cycle only and a
  // done is honoured only in its own state after that entry cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cur_state_reg  <= '0;
      next_reg       <= '0;
      episode_reg    <= 8'd0;
      step_reg       <= 8'd0;
      maxq_go_reg    <= 1'b0;
      update_go_reg  <= 1'b0;
      trial_go_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      learn_done_reg <= 1'b0;
`ifdef Q_SCHED_WATCHDOG_EN
      err_reg        <= 1'b0;
`endif
    end else begin
      maxq_go_reg   <= 1'b0;
      update_go_reg <= 1'b0;
      trial_go_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= WAIT_INIT;
            busy_reg  <= 1'b1;
          end
        end
        WAIT_INIT: begin
          if (init_done) begin
            state_reg     <= MAXQ;
            maxq_go_reg   <= 1'b1;
            cur_state_reg <= start_state;
            episode_reg   <= 8'd0;
            step_reg      <= 8'd0;
          end
        end
        MAXQ: begin
          if (maxq_done && !maxq_go_reg) begin
            state_reg     <= UPDATE;
            update_go_reg <= 1'b1;
          end
`ifdef Q_SCHED_WATCHDOG_EN
          else if (wd_expire) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            learn_done_reg <= 1'b1;
            err_reg        <= 1'b1;
          end
`endif
        end
        UPDATE: begin
          if (update_done && !update_go_reg) begin
            state_reg    <= TRIAL;
            trial_go_reg <= 1'b1;
          end
`ifdef Q_SCHED_WATCHDOG_EN
          else if (wd_expire) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            learn_done_reg <= 1'b1;
            err_reg        <= 1'b1;
          end
`endif
        end
        TRIAL: begin
          if (trial_done && !trial_go_reg) begin
            state_reg <= CHECK;
            next_reg  <= trial_next;
          end
`ifdef Q_SCHED_WATCHDOG_EN
          else if (wd_expire) begin
            state_reg      <= DONE;
            busy_reg       <= 1'b0;
            learn_done_reg <= 1'b1;
            err_reg        <= 1'b1;
          end
`endif
        end
        CHECK: begin
          // Target hit and step cap together still count as one episode end
          if (target_hit || step_cap) begin
            episode_reg   <= episode_inc;
            step_reg      <= 8'd0;
            cur_state_reg <= start_state;
            if (last_episode) begin
              state_reg      <= DONE;
              busy_reg       <= 1'b0;
              learn_done_reg <= 1'b1;
            end else begin
              state_reg   <= MAXQ;
              maxq_go_reg <= 1'b1;
            end
          end else begin
            cur_state_reg <= next_reg;
            step_reg      <= step_inc;
            state_reg     <= MAXQ;
            maxq_go_reg   <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_reg      <= WAIT_INIT;
            busy_reg       <= 1'b1;
            learn_done_reg <= 1'b0;
`ifdef Q_SCHED_WATCHDOG_EN
            err_reg        <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign maxq_go    = maxq_go_reg;
  assign update_go  = update_go_reg;
  assign trial_go   = trial_go_reg;
  assign cur_state  = cur_state_reg;
  assign episode    = episode_reg;
  assign step       = step_reg;
  assign busy       = busy_reg;
  assign learn_done = learn_done_reg;

endmodule

// File: tb/tb_q_episode_sched.sv
// Scoreboard bench for q_episode_sched: the stimulus side plays the three
// datapath units and a reference model predicts the state presented at each
// maxq_go and at run completion; a monitor pops and compares.
module tb_q_episode_sched;

  localparam int N_EP   = 2;
  localparam int MAX_ST = 4;

  logic       clk = 1'b0;
  logic       rst, start, init_done;
  logic [5:0] start_state, target_state, trial_next;
  logic       maxq_go, update_go, trial_go;
  logic       maxq_done, update_done, trial_done;
  logic [5:0] cur_state;
  logic [7:0] episode, step;
  logic       busy, learn_done, err;

  q_episode_sched #(.N_EPISODES(N_EP), .MAX_STEPS(MAX_ST)) dut (
    .clk(clk), .rst(rst), .start(start), .init_done(init_done),
    .start_state(start_state), .target_state(target_state),
    .maxq_go(maxq_go), .update_go(update_go), .trial_go(trial_go),
    .maxq_done(maxq_done), .update_done(update_done), .trial_done(trial_done),
    .trial_next(trial_next), .cur_state(cur_state), .episode(episode),
    .step(step), .busy(busy), .learn_done(learn_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [5:0] cur;
    logic [7:0] ep;
    logic [7:0] st;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] script_q[$];
  int         checks = 0;
  int         fails  = 0;
  int         txn    = 0;
  bit         mon_en = 0;
  bit         ld_prev = 0, mg_prev = 0, ug_prev = 0, tg_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit sig_of(input int which);
    case (which)
      0: return maxq_go;
      1: return update_go;
      2: return trial_go;
      default: return learn_done;
    endcase
  endfunction

  task automatic set_done(input int which, input logic v);
    case (which)
      0: maxq_done = v;
      1: update_done = v;
      default: trial_done = v;
    endcase
  endtask

  // Checks the current negedge first, then waits up to limit cycles
  task automatic wait_sig(input int which, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (sig_of(which)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL wait_sig%0d actual=timeout required=pulse within %0d cycles", which, limit);
    end
  endtask

  // Called at the negedge where the unit's go is visible
  task automatic respond(input int which, input logic [5:0] nxt);
    if (which < 2 && $urandom_range(0, 3) == 0) begin
      // done in the go cycle must be ignored
      set_done(which, 1'b1);
      @(negedge clk);
      set_done(which, 1'b0);
      chk("early_done_ignored", {31'd0, sig_of(which + 1)}, 0);
    end else begin
      @(negedge clk);
    end
    if (which == 0 && $urandom_range(0, 2) == 0) begin
      update_done = 1'b1;
      trial_done  = 1'b1;
      start       = 1'b1;
      trial_next  = 6'($urandom_range(0, 36));
      @(negedge clk);
      update_done = 1'b0;
      trial_done  = 1'b0;
      start       = 1'b0;
      chk("stray_done_ignored", {31'd0, update_go | trial_go}, 0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (which == 2) trial_next = nxt;
    set_done(which, 1'b1);
    @(negedge clk);
    set_done(which, 1'b0);
  endtask

  task automatic begin_run(input logic [5:0] s, input logic [5:0] t);
    start_state  = s;
    target_state = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_learn_done_clear", {31'd0, learn_done}, 0);
    repeat (2) @(negedge clk);
    init_done = 1'b1;
  endtask

  // One full learning run driven against the reference model
  task automatic do_run(input logic [5:0] s, input logic [5:0] t, input int hit_pct);
    int         ep;
    int         st;
    logic [5:0] nxt;
    bit         ok;
    ep = 0;
    st = 0;
    ok = 1;
    begin_run(s, t);
    exp_q.push_back('{is_done: 0, cur: s, ep: 8'd0, st: 8'd0});
    @(negedge clk);
    init_done = 1'b0;
    while (ep < N_EP) begin
      wait_sig(0, 40, ok); if (!ok) break;
      respond(0, 6'd0);
      wait_sig(1, 40, ok); if (!ok) break;
      respond(1, 6'd0);
      wait_sig(2, 40, ok); if (!ok) break;
      if (script_q.size() > 0) nxt = script_q.pop_front();
      else if ($urandom_range(0, 99) < hit_pct) nxt = t;
      else begin
        do nxt = 6'($urandom_range(0, 36)); while (nxt == t);
      end
      respond(2, nxt);
      if (nxt == t || st + 1 == MAX_ST) begin
        ep++;
        st = 0;
        exp_q.push_back('{is_done: (ep == N_EP), cur: s, ep: 8'(ep), st: 8'd0});
      end else begin
        st++;
        exp_q.push_back('{is_done: 0, cur: nxt, ep: 8'(ep), st: 8'(st)});
      end
    end
    if (ok) begin
      wait_sig(3, 20, ok);
      repeat (4) @(negedge clk);
      chk("done_hold_learn_done", {31'd0, learn_done}, 1);
      chk("done_hold_busy", {31'd0, busy}, 0);
      chk("queue_drained", exp_q.size(), 0);
    end else begin
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    script_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cur_state"}, {26'd0, cur_state}, 0);
    chk({tag, "_episode"}, {24'd0, episode}, 0);
    chk({tag, "_step"}, {24'd0, step}, 0);
    chk({tag, "_flags"}, {26'd0, busy, learn_done, err, maxq_go, update_go, trial_go}, 0);
  endtask

  task automatic reset_in_trial();
    bit   ok;
    logic any_act;
    begin_run(6'd7, 6'd9);
    @(negedge clk);
    init_done = 1'b0;
    wait_sig(0, 40, ok); respond(0, 6'd0);
    wait_sig(1, 40, ok); respond(1, 6'd0);
    wait_sig(2, 40, ok); respond(2, 6'd9);
    wait_sig(0, 40, ok); respond(0, 6'd0);
    wait_sig(1, 40, ok); respond(1, 6'd0);
    wait_sig(2, 40, ok);
    chk("pre_reset_episode", {24'd0, episode}, 1);
    chk("pre_reset_cur_state", {26'd0, cur_state}, 7);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset_in_trial");
    rst = 1'b0;
    trial_next  = 6'd9;
    trial_done  = 1'b1;
    maxq_done   = 1'b1;
    update_done = 1'b1;
    @(negedge clk);
    trial_done  = 1'b0;
    maxq_done   = 1'b0;
    update_done = 1'b0;
    any_act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_act = any_act | busy | maxq_go | update_go | trial_go | learn_done;
    end
    chk("late_done_after_reset", {31'd0, any_act}, 0);
  endtask

  task automatic hang_test();
    bit ok;
    int k;
    begin_run(6'd2, 6'd30);
    @(negedge clk);
    init_done = 1'b0;
    wait_sig(0, 40, ok);
    k = 0;
`ifdef Q_SCHED_WATCHDOG_EN
    while (k < 300 && !learn_done) begin
      @(negedge clk);
      k++;
    end
    chk("wd_expire_cycles", k, 256);
    chk("wd_err", {31'd0, err}, 1);
    chk("wd_busy", {31'd0, busy}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wd_err_cleared_by_start", {31'd0, err}, 0);
`else
    repeat (300) @(negedge clk);
    chk("nowd_err", {31'd0, err}, 0);
    chk("nowd_busy", {31'd0, busy}, 1);
    chk("nowd_learn_done", {31'd0, learn_done}, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares DUT presentations against the scoreboard queue
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (maxq_go) chk("maxq_go_width", {31'd0, mg_prev}, 0);
      if (update_go) chk("update_go_width", {31'd0, ug_prev}, 0);
      if (trial_go) chk("trial_go_width", {31'd0, tg_prev}, 0);
      if (maxq_go) begin
        if (exp_q.size() == 0) begin
          chk("maxq_go_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d maxq_go cur=%0d episode=%0d step=%0d", txn, cur_state, episode, step);
          chk("maxq_go_kind", {31'd0, e.is_done}, 0);
          chk("maxq_cur_state", {26'd0, cur_state}, {26'd0, e.cur});
          chk("maxq_episode", {24'd0, episode}, {24'd0, e.ep});
          chk("maxq_step", {24'd0, step}, {24'd0, e.st});
          chk("maxq_busy", {31'd0, busy}, 1);
        end
      end
      if (learn_done && !ld_prev) begin
        if (exp_q.size() == 0) begin
          chk("learn_done_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d learn_done episode=%0d cur=%0d", txn, episode, cur_state);
          chk("done_kind", {31'd0, e.is_done}, 1);
          chk("done_episode", {24'd0, episode}, {24'd0, e.ep});
          chk("done_cur_state", {26'd0, cur_state}, {26'd0, e.cur});
          chk("done_step", {24'd0, step}, 0);
          chk("done_busy", {31'd0, busy}, 0);
        end
      end
    end
    ld_prev = learn_done;
    mg_prev = maxq_go;
    ug_prev = update_go;
    tg_prev = trial_go;
  end

  initial begin
    rst = 1'b1; start = 1'b0; init_done = 1'b0;
    start_state = '0; target_state = '0; trial_next = '0;
    maxq_done = 1'b0; update_done = 1'b0; trial_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1;
    // Trials 1,2,3 to target 3, then an immediate hit ends the run
    script_q = '{6'd1, 6'd2, 6'd3, 6'd3};
    do_run(6'd0, 6'd3, 0);
    // Immediate hit in both episodes
    script_q = '{6'd3, 6'd3};
    do_run(6'd0, 6'd3, 0);
    // Target reached on the capped step: single increment
    script_q = '{6'd1, 6'd2, 6'd4, 6'd9, 6'd9};
    do_run(6'd5, 6'd9, 0);
    // Target never hit: each episode ends on the step cap
    do_run(6'd12, 6'd20, 0);
    for (int r = 0; r < 4; r++) begin
      do_run(6'($urandom_range(0, 36)), 6'($urandom_range(0, 36)), 30);
    end
    mon_en = 0;
    reset_in_trial();
    hang_test();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "global timeout");
  end

endmodule
